axis_video_out: RTL and testbench

- Downstream sink for the frame streamer / pixel pipeline: consumes an AXI4-Stream pixel stream (TUSER = start of frame, TLAST = last pixel of frame) and drives a VGA-style display interface.
- Contains an internal pixel FIFO, an H/V timing generator, and a frame-alignment state machine that locks the stream to the raster.
- Raises status pulses on underflow or on loss of frame alignment.

---
 rtl/axis_video_out_pkg.sv | 35 +++
 rtl/axi4s_if.sv | 19 +
 rtl/axis_video_out_fifo.sv | 41 ++++
 rtl/axis_video_out.sv | 172 +++++++++++++++++
 tb/tb_axis_video_out.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/axis_video_out_pkg.sv
// Shared types for the AXI4-Stream video output: raster timing record,
// the reference 1024x768@60 timing and the frame-alignment state encoding.
package axis_video_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vid_timing_t;

    localparam vid_timing_t TIMING_1024x768_60 = '{
        h_active: 32'd1024, h_fp: 32'd24, h_sync: 32'd136, h_bp: 32'd160,
        v_active: 32'd768,  v_fp: 32'd3,  v_sync: 32'd6,   v_bp: 32'd29
    };

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        WAIT   = 2'd1,
        RUN    = 2'd2
    } vout_state_e;

    function automatic int vid_h_total(input vid_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int vid_v_total(input vid_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/axi4s_if.sv
// AXI4-Stream bundle with master/slave modports.
interface axi4s_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic [USER_WIDTH-1:0]     tuser;
    logic                      tlast;
    logic [ID_WIDTH-1:0]       tid;
    logic [DEST_WIDTH-1:0]     tdest;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_video_out_fifo.sv
// Single-clock FIFO with first-word-fall-through head output; extra
// pointer bit distinguishes full from empty.
module axis_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset empties the FIFO immediately
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop && !empty) rd_ptr_r <= rd_ptr_r + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk_i) begin
        if (push && !full) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/axis_video_out.sv
// AXI4-Stream to VGA-style raster output with frame-alignment FSM.
// Optional AXIS_VIDEO_OUT_STATS_EN adds frame/error counters.
module axis_video_out
    import axis_video_pkg::*;
#(
    parameter int H_ACTIVE   = TIMING_1024x768_60.h_active,
    parameter int H_FP       = TIMING_1024x768_60.h_fp,
    parameter int H_SYNC     = TIMING_1024x768_60.h_sync,
    parameter int H_BP       = TIMING_1024x768_60.h_bp,
    parameter int V_ACTIVE   = TIMING_1024x768_60.v_active,
    parameter int V_FP       = TIMING_1024x768_60.v_fp,
    parameter int V_SYNC     = TIMING_1024x768_60.v_sync,
    parameter int V_BP       = TIMING_1024x768_60.v_bp,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi4s_if.slave                s_axis,
    output logic [DATA_WIDTH-1:0] rgb_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  de_o,
    output logic                  locked_o,
    output logic                  underflow_o,
    output logic                  sync_err_o
`ifdef AXIS_VIDEO_OUT_STATS_EN
    ,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           err_cnt_o
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0]         h_cnt_r;
    logic [VW-1:0]         v_cnt_r;
    vout_state_e           state_r;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic [EW-1:0]         fifo_din_s;
    logic [EW-1:0]         fifo_head_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_user_s;
    logic                  head_last_s;
    logic                  active_s;
    logic                  hsync_s;
    logic                  vsync_s;
    logic                  origin_s;
    logic                  last_pos_s;
    logic                  frame_end_s;
    logic                  run_active_s;
    logic                  run_pix_s;
    logic                  pix_err_s;
    logic                  underflow_s;
    logic                  sync_err_s;

    assign fifo_din_s  = {s_axis.tlast, s_axis.tuser[0], s_axis.tdata[DATA_WIDTH-1:0]};
    assign fifo_push_s = s_axis.tvalid && !fifo_full_s;
    assign s_axis.tready = !fifo_full_s;
    assign {head_last_s, head_user_s, head_data_s} = fifo_head_s;

    axis_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .wr_data (fifo_din_s),
        .head    (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign active_s     = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
    assign hsync_s      = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
    assign vsync_s      = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);
    assign origin_s     = (h_cnt_r == HW'(0)) && (v_cnt_r == VW'(0));
    assign last_pos_s   = (h_cnt_r == H_ACT_LAST) && (v_cnt_r == V_ACT_LAST);
    assign frame_end_s  = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    assign run_active_s = (state_r == RUN) && active_s;
    assign run_pix_s    = run_active_s && !fifo_empty_s;
    // Pixel disagrees with the raster: stray SOF, or TLAST not exactly at the final pixel
    assign pix_err_s    = (head_user_s && !origin_s) || (head_last_s != last_pos_s);
    assign underflow_s  = run_active_s && fifo_empty_s;
    assign sync_err_s   = run_pix_s && pix_err_s;

    // Pop decision per alignment state
    always_comb begin
        fifo_pop_s = 1'b0;
        case (state_r)
            RESYNC:  fifo_pop_s = !fifo_empty_s && !head_user_s;
            WAIT:    fifo_pop_s = 1'b0;
            RUN:     fifo_pop_s = run_pix_s;
            default: fifo_pop_s = 1'b0;
        endcase
    end

    // Free-running raster counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_r <= HW'(0);
            v_cnt_r <= VW'(0);
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= HW'(0);
            v_cnt_r <= (v_cnt_r == V_LAST) ? VW'(0) : v_cnt_r + 1'b1;
        end else begin
            h_cnt_r <= h_cnt_r + 1'b1;
        end
    end

    // Alignment FSM and registered display outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= RESYNC;
            rgb_o       <= {DATA_WIDTH{1'b0}};
            de_o        <= 1'b0;
            hs_o        <= ~HS_POL;
            vs_o        <= ~VS_POL;
            locked_o    <= 1'b0;
            underflow_o <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            rgb_o       <= run_pix_s ? head_data_s : {DATA_WIDTH{1'b0}};
            de_o        <= active_s;
            hs_o        <= hsync_s ? HS_POL : ~HS_POL;
            vs_o        <= vsync_s ? VS_POL : ~VS_POL;
            locked_o    <= (state_r == RUN);
            underflow_o <= underflow_s;
            sync_err_o  <= sync_err_s;
            case (state_r)
                RESYNC:  state_r <= (!fifo_empty_s && head_user_s) ? WAIT : RESYNC;
                WAIT:    state_r <= frame_end_s ? RUN : WAIT;
                RUN:     state_r <= (underflow_s || sync_err_s) ? RESYNC : RUN;
                default: state_r <= RESYNC;
            endcase
        end
    end

`ifdef AXIS_VIDEO_OUT_STATS_EN
    // Completed-frame and saturating error counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_o <= 16'd0;
            err_cnt_o   <= 16'd0;
        end else begin
            if (run_pix_s && last_pos_s && !pix_err_s) frame_cnt_o <= frame_cnt_o + 16'd1;
            if ((underflow_s || sync_err_s) && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_video_out.sv
// Randomized scoreboard bench for axis_video_out on a small 8x4 raster.
module tb_axis_video_out;
    localparam int H_ACT = 8, H_FP = 2, H_SY = 2, H_BP = 2;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int DEPTH = 4;
    localparam int NPIX  = H_ACT * V_ACT;
    localparam int M_HUNT = 0, M_ARMED = 1, M_LOCK = 2;

    typedef struct { logic [15:0] data; bit user; bit last; } beat_t;
    typedef struct {
        logic [15:0] rgb; bit de; bit hs; bit vs; bit lock; bit uf; bit se;
        logic [15:0] fc; logic [15:0] ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] rgb;
    logic hs, vs, de, locked, underflow, sync_err;
    logic [15:0] frame_cnt, err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cycle = 0;

    axi4s_if #(.DATA_WIDTH(16)) s_if ();

    axis_video_out #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_axis(s_if),
        .rgb_o(rgb), .hs_o(hs), .vs_o(vs), .de_o(de), .locked_o(locked),
        .underflow_o(underflow), .sync_err_o(sync_err)
`ifdef AXIS_VIDEO_OUT_STATS_EN
        , .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
`endif
    );

`ifndef AXIS_VIDEO_OUT_STATS_EN
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif

    always #5 clk = ~clk;

    // Reference model: beats held in a queue, raster position from plain arithmetic
    beat_t q_m[$];
    exp_t  exp_q[$];
    int h_m = 0, v_m = 0, mode_m = M_HUNT;
    logic [15:0] fc_m = 16'd0, ec_m = 16'd0;

    always @(posedge clk) begin
        exp_t e;
        beat_t b;
        bit act, room, bad;
        cycle++;
        e.rgb = 16'd0; e.de = 0; e.hs = 1; e.vs = 1; e.lock = 0; e.uf = 0; e.se = 0;
        if (rst) begin
            q_m.delete();
            h_m = 0; v_m = 0; mode_m = M_HUNT; fc_m = 16'd0; ec_m = 16'd0;
        end else begin
            act  = (h_m < H_ACT) && (v_m < V_ACT);
            room = q_m.size() < DEPTH;
            e.de = act;
            e.hs = !(h_m >= H_ACT + H_FP && h_m < H_ACT + H_FP + H_SY);
            e.vs = !(v_m >= V_ACT + V_FP && v_m < V_ACT + V_FP + V_SY);
            e.lock = (mode_m == M_LOCK);
            if (mode_m == M_HUNT) begin
                if (q_m.size() > 0) begin
                    if (q_m[0].user) mode_m = M_ARMED;
                    else void'(q_m.pop_front());
                end
            end else if (mode_m == M_ARMED) begin
                if (h_m == H_TOT - 1 && v_m == V_TOT - 1) mode_m = M_LOCK;
            end else if (act) begin
                if (q_m.size() == 0) begin
                    e.uf = 1; mode_m = M_HUNT;
                end else begin
                    b = q_m.pop_front();
                    e.rgb = b.data;
                    bad = (b.user && (h_m != 0 || v_m != 0)) ||
                          (b.last != (h_m == H_ACT - 1 && v_m == V_ACT - 1));
                    if (bad) begin e.se = 1; mode_m = M_HUNT; end
                    else if (b.last) fc_m = fc_m + 16'd1;
                end
                if ((e.uf || e.se) && ec_m != 16'hFFFF) ec_m = ec_m + 16'd1;
            end
            if (s_if.tvalid && room) begin
                b.data = s_if.tdata; b.user = s_if.tuser[0]; b.last = s_if.tlast;
                q_m.push_back(b);
            end
            h_m = (h_m + 1) % H_TOT;
            if (h_m == 0) v_m = (v_m + 1) % V_TOT;
        end
        e.fc = fc_m; e.ec = ec_m;
        exp_q.push_back(e);
        if (cycle > 60000) begin
            $display("FAIL watchdog cycle=%0d limit=60000", cycle);
            $fatal(1, "watchdog");
        end
    end

    // Monitor: one expected record per output cycle
    always @(negedge clk) begin
        exp_t e;
        logic [22:0] got, want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got  = {rgb, de, hs, vs, locked, underflow, sync_err};
            want = {e.rgb, e.de, e.hs, e.vs, e.lock, e.uf, e.se};
            n_chk++;
            if (got !== want) begin
                n_err++;
                if (n_err < 40) $display("FAIL outputs cyc=%0d {rgb,de,hs,vs,lock,uf,se} got=%h want=%h", cycle, got, want);
            end
            n_chk++;
            if (s_if.tready !== (q_m.size() < DEPTH)) begin
                n_err++;
                if (n_err < 40) $display("FAIL tready cyc=%0d got=%b want=%b", cycle, s_if.tready, q_m.size() < DEPTH);
            end
`ifdef AXIS_VIDEO_OUT_STATS_EN
            n_chk++;
            if ({frame_cnt, err_cnt} !== {e.fc, e.ec}) begin
                n_err++;
                if (n_err < 40) $display("FAIL stats cyc=%0d got=%h/%h want=%h/%h", cycle, frame_cnt, err_cnt, e.fc, e.ec);
            end
`endif
        end
    end

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic send_beat(input logic [15:0] d, input bit u, input bit l);
        bit acc;
        int n = 0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = l;
        do begin
            acc = s_if.tready;
            @(posedge clk); @(negedge clk);
            n++;
        end while (!acc && n < 1000);
        s_if.tvalid = 1'b0;
        if (!acc) begin
            $display("FAIL handshake_timeout got=stalled want=accepted");
            n_err++;
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $fatal(1, "handshake");
        end
    endtask

    // One frame: frame number in high byte, pixel index in low byte
    task automatic send_frame(input int f, input int start, input int gap_pct,
                              input bit bad_last, input int stall_at);
        for (int p = start; p < NPIX; p++) begin
            if (p == stall_at) idle(20);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            send_beat({f[7:0], p[7:0]}, p == 0, bad_last ? (p == NPIX - 2) : (p == NPIX - 1));
        end
    endtask

    task automatic wait_lock(input string name, input int budget);
        int n = 0;
        while (locked !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL %s got=locked_o:%b want=1 within %0d cycles", name, locked, budget);
        end
    endtask

    initial begin
        int f;
        int st;
        s_if.tvalid = 1'b0; s_if.tdata = 16'd0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        s_if.tkeep = 2'b11; s_if.tid = 1'b0; s_if.tdest = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Mid-frame start, then clean frames
        fork
            begin
                send_frame(0, 13, 0, 1'b0, -1);
                for (int i = 1; i < 4; i++) send_frame(i, 0, 0, 1'b0, -1);
            end
            wait_lock("lock_after_midframe", 400);
        join
        // Source stall inside active area
        send_frame(4, 0, 0, 1'b0, 12);
        send_frame(5, 0, 0, 1'b0, -1);
        send_frame(6, 0, 0, 1'b0, -1);
        wait_lock("relock_after_underflow", 300);
        // TLAST one pixel early
        send_frame(7, 0, 0, 1'b1, -1);
        send_frame(8, 0, 0, 1'b0, -1);
        send_frame(9, 0, 0, 1'b0, -1);
        wait_lock("relock_after_sync_err", 300);
        // One-cycle reset in the middle of an active line
        fork
            for (int i = 10; i < 13; i++) send_frame(i, 0, 0, 1'b0, -1);
            begin
                int n = 0;
                while (!(h_m == 3 && v_m == 1 && locked === 1'b1) && n < 500) begin @(negedge clk); n++; end
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        send_frame(13, 0, 0, 1'b0, -1);
        send_frame(14, 0, 0, 1'b0, -1);
        wait_lock("relock_after_reset", 300);
        // Randomized traffic with gaps, partial frames and occasional bad TLAST
        for (int i = 0; i < 12; i++) begin
            f  = 15 + i;
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(1, NPIX - 1) : 0;
            send_frame(f, st, $urandom_range(0, 25), $urandom_range(0, 5) == 0, -1);
        end
        idle(200);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
